// File: rtl/aes_pkg.sv
// Shared AES types and S-box tables. SUB_BYTES_INV_EN also compiles in the inverse S-box.
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:15] state_t;  // element 0 is the MSB byte (FIPS-197 byte 0)

    typedef enum logic [1:0] {IDLE, BUSY, DONE} sb_state_e;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_BYTES_INV_EN
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
`endif

endpackage

// File: rtl/aes_sbox.sv
// Single-byte combinational S-box. The inv port exists only when SUB_BYTES_INV_EN is defined.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
`ifdef SUB_BYTES_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] out
);

`ifdef SUB_BYTES_INV_EN
    assign out = inv ? INV_SBOX[a] : SBOX[a];
`else
    assign out = SBOX[a];
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// Sequential SubBytes/InvSubBytes over a rotating 128-bit state, LANES bytes per beat.
// SUB_BYTES_INV_EN enables the inverse mode; otherwise the engine is forward-only.
module sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = 8 * LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    sb_state_e             state, nxt;
    state_t                sreg;
    logic [127:0]          sflat;
    logic [127:0]          rot;
    logic [CW-1:0]         beat;
    logic                  mode;
    logic                  accept;
    logic                  last_beat;
    logic [LANES-1:0][7:0] lane_in;
    logic [LANES-1:0][7:0] lane_out;

    assign sflat     = sreg;
    assign out_data  = sflat;
    assign accept    = in_valid & in_ready;
    assign last_beat = (beat == CW'(BEATS - 1));
    assign lane_in   = sflat[127 -: LW];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox u_sbox (
            .a   (lane_in[i]),
`ifdef SUB_BYTES_INV_EN
            .inv (mode),
`endif
            .out (lane_out[i])
        );
    end

    // Substituted bytes re-enter at the bottom, so after BEATS rotations the order is restored.
    if (BEATS == 1) begin : g_rot_full
        assign rot = lane_out;
    end else begin : g_rot
        assign rot = {sflat[127-LW:0], lane_out};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (accept) nxt = BUSY;
            BUSY:    if (last_beat) nxt = DONE;
            DONE:    if (out_ready) nxt = accept ? BUSY : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg <= '0;
            beat <= '0;
        end else if (accept) begin
            sreg <= in_data;
            beat <= '0;
        end else if (state == BUSY) begin
            sreg <= rot;
            beat <= last_beat ? '0 : beat + 1'b1;
        end
    end

`ifdef SUB_BYTES_INV_EN
    always_ff @(posedge clk) begin
        if (rst)         mode <= 1'b0;
        else if (accept) mode <= in_inv;
    end
`else
    logic unused_inv;
    assign mode       = 1'b0;
    assign unused_inv = in_inv ^ mode;
`endif

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Scoreboard bench for sub_bytes_engine: FIPS-197 vectors, back-pressure, reset and LANES sweep.
module tb_sub_bytes_engine;

    typedef struct {
        logic [127:0] data;
        int           acc;
    } exp_t;

    localparam logic [127:0] FIPS_IN  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
    localparam logic [127:0] FIPS_OUT = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [127:0] SEQ_IN   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_OUT  = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ONES_OUT = {16{8'h16}};
`ifdef SUB_BYTES_INV_EN
    localparam logic [127:0] ZERO_INV_OUT = {16{8'h52}};
`else
    localparam logic [127:0] ZERO_INV_OUT = {16{8'h63}};
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic         in_inv = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         extra_go = 1'b0;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    bit   seen_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_engine #(.LANES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    function automatic void chk(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    // Monitor: latency on the rising out_valid, stability under back-pressure, data on handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", out_valid, 1'b0);
            end else begin
                if (!seen_valid) begin
                    chk("latency", 128'(cyc - q[0].acc + 1), 128'd5);
                    seen_valid = 1'b1;
                end
                if (out_ready) begin
                    chk("out_data", out_data, q[0].data);
                    void'(q.pop_front());
                    seen_valid = 1'b0;
                end else begin
                    chk("stall_data", out_data, q[0].data);
                    chk("stall_in_ready", in_ready, 1'b0);
                end
            end
        end
    end

    // Called at posedge+#1; returns number of cycles spent waiting for in_ready.
    task automatic send(input logic [127:0] d, input logic inv, input bit exp_out,
                        input logic [127:0] exp_d, output int waits);
        logic rdy;
        int   k;
        rdy = 1'b0;
        k = 0;
        waits = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (waits < 50) begin
            @(negedge clk);
            rdy = in_ready;
            k = cyc;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
        end
        in_valid = 1'b0;
        chk("send_in_ready", rdy, 1'b1);
        if (rdy && exp_out) q.push_back('{exp_d, k + 1});
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
        chk("drain_empty", 128'(q.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    // Other legal LANES builds: FIPS first-row vector with per-build latency.
    for (genvar g = 0; g < 4; g++) begin : g_lanes
        localparam int LN  = (g < 2) ? (1 << g) : (1 << (g + 1));
        localparam int LAT = (g == 0) ? 17 : (g == 1) ? 9 : (g == 2) ? 3 : 2;
        logic         x_iv = 1'b0;
        logic         x_ir;
        logic         x_ov;
        logic [127:0] x_od;
        logic         done = 1'b0;

        sub_bytes_engine #(.LANES(LN)) u_x (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (x_iv),
            .in_ready  (x_ir),
            .in_data   (SEQ_IN),
            .in_inv    (1'b0),
            .out_valid (x_ov),
            .out_ready (1'b1),
            .out_data  (x_od)
        );

        initial begin
            int n;
            n = 0;
            wait (extra_go);
            repeat (25 * g + 1) @(posedge clk);
            #1 x_iv = 1'b1;
            @(negedge clk);
            chk($sformatf("lanes%0d_in_ready", LN), x_ir, 1'b1);
            @(posedge clk);
            #1 x_iv = 1'b0;
            while (n < 40) begin
                @(negedge clk);
                n++;
                if (x_ov) break;
            end
            chk($sformatf("lanes%0d_latency", LN), 128'(n), 128'(LAT));
            chk($sformatf("lanes%0d_data", LN), x_od, SEQ_OUT);
            done = 1'b1;
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        @(posedge clk);
        #1;

        send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT, w);
        drain();
        send(SEQ_IN, 1'b0, 1'b1, SEQ_OUT, w);
        drain();
        send({16{8'hff}}, 1'b0, 1'b1, ONES_OUT, w);
        drain();
        send('0, 1'b1, 1'b1, ZERO_INV_OUT, w);
        drain();
`ifdef SUB_BYTES_INV_EN
        send(FIPS_OUT, 1'b1, 1'b1, FIPS_IN, w);
        drain();
`endif

        // Back-pressure, then same-cycle accept when out_ready rises.
        out_ready = 1'b0;
        send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT, w);
        for (int t = 0; t < 40 && !out_valid; t++) @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        send(SEQ_IN, 1'b0, 1'b1, SEQ_OUT, w);
        chk("bp_same_cycle_accept", 128'(w), 128'd0);
        @(negedge clk);
        chk("bp_busy_out_valid", out_valid, 1'b0);
        drain();

        // Reset on the second BUSY beat discards the operation.
        send(SEQ_IN, 1'b0, 1'b0, '0, w);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, '0);
        repeat (8) @(posedge clk);
        #1;
        send(FIPS_IN, 1'b0, 1'b1, FIPS_OUT, w);
        drain();

        // Inputs wiggle while busy; result must reflect the accepted value.
        send(SEQ_IN, 1'b0, 1'b1, SEQ_OUT, w);
        for (int t = 0; t < 6; t++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_inv  = ~in_inv;
            @(posedge clk);
            #1;
        end
        in_inv = 1'b0;
        drain();

        extra_go = 1'b1;
        for (int t = 0; t < 300 && !(g_lanes[0].done && g_lanes[1].done &&
                                     g_lanes[2].done && g_lanes[3].done); t++)
            @(posedge clk);
        chk("lanes_sweep_done",
            {g_lanes[0].done, g_lanes[1].done, g_lanes[2].done, g_lanes[3].done}, 4'hf);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
# sub_bytes_engine

Sequential, parametrised AES SubBytes / InvSubBytes engine: accepts a 128-bit AES state over a valid/ready handshake and substitutes `LANES` bytes per clock through `LANES` S-box instances. It trades area for latency against the existing purely combinational 16-S-box `substitute` block. It sits between AddRoundKey and ShiftRows in the round datapath and in the key-expansion SubWord path (the `LANES=4` build).

## Interface
- `LANES`, default 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `clk`  in  1  rising-edge clock; sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data`/`in_inv` valid.
- `in_ready`  out  1  engine can accept a state this cycle.
- `in_data`  in  128  AES state; byte 0 = bits [127:120], column-major in FIPS-197 order.
- `in_inv`  in  1  0 = SubBytes, 1 = InvSubBytes; sampled at accept.
- `out_valid`  out  1  `out_data` holds a finished result.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_data`  out  128  substituted state, same byte order as `in_data`.

## Operation
- **FSM states**
  - IDLE: `in_ready`=1. An accept (`in_valid & in_ready`) loads `in_data` and latches `in_inv` into `mode`. Clears the beat counter. Next state is BUSY.
  - BUSY: each cycle, the top `LANES` bytes of the state register pass through the S-boxes. The register rotates left by 8·`LANES` bits, and the substituted bytes enter the LSBs. After `16/LANES` beats the register holds the full result in original byte order. Next state is DONE.
  - DONE: `out_valid`=1 and `out_data` is stable.
    - `out_ready`=1 and no new accept: next state is IDLE.
    - `out_ready`=1 and `in_valid`=1: the new state is accepted in the same cycle (`in_ready` = `out_ready` in DONE), and the next state is BUSY.
- Beat counter width is `$clog2(16/LANES)`, minimum 1 bit. It wraps to 0 on the last beat.
- `LANES=16`: BUSY lasts exactly one cycle.
- `in_inv` and `in_data` are ignored outside an accept cycle. Changing them during BUSY has no effect.
- `out_data` equals the state register. In IDLE and BUSY its value is don't-care for consumers, but it is deterministic: the last result, or a partial rotation.
- Reset
  - Value after reset: state IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `mode`=0, counter 0.
  - Reset asserted mid-BUSY or in DONE discards the operation. No output is produced for it.

## Timing
- Accept at edge N → BUSY edges N+1 … N+16/`LANES` → `out_valid`=1 from cycle N+16/`LANES`+1.
  - Latency 17 (`LANES`=1), 9 (2), 5 (4), 3 (8), 2 (16) cycles.
- Sustained throughput with `out_ready` tied high: one state per 16/`LANES`+1 cycles.
- No combinational path from `in_valid` to `in_ready`.
- `in_ready` in DONE depends combinationally on `out_ready`. This is the only in→out combinational path.
- `out_valid`, once high, stays high and `out_data` stays stable until `out_ready`=1.

## Configuration
- `SUB_BYTES_INV_EN` defined: the inverse S-box table is compiled in. `mode`=1 selects InvSubBytes per lane.
- Not defined: only the forward table exists, `in_inv` is ignored, `mode` is tied 0, and the engine always performs SubBytes. This is the area-saving encrypt-only build.

## Structure
- Shared package `aes_pkg` holds:
  - the 256-entry forward S-box constant `SBOX`;
  - the inverse constant `INV_SBOX`, guarded by the macro;
  - the byte typedef `byte_t`;
  - the state typedef `state_t` (16 × `byte_t`);
  - the FSM state enum `sb_state_e` {IDLE, BUSY, DONE}.
- Sub-module `aes_sbox`: one byte, combinational, ports `a`[7:0], `inv`, `out`[7:0]. It is instantiated `LANES` times in a generate loop. Its `inv` port exists only under `SUB_BYTES_INV_EN`.

## Test plan
- **FIPS-197 vector, `LANES`=4, fwd:** `in_data`=19a09ae93df4c6f8e3e28d48be2b2a08 → `out_data`=d4e0b81e27bfb44111985d52aef1e530, `out_valid` exactly 5 cycles after accept.
- **Same vector, `in_inv`=1 (INV_EN built):** input d4e0b81e27bfb44111985d52aef1e530 → 19a09ae93df4c6f8e3e28d48be2b2a08. Without the macro, `in_inv`=1 on input 00…00 yields 6363…63.
- **Every legal `LANES`:** input 000102…0f → 637c777bf26b6fc53001672bfed7ab76, with latency 17/9/5/3/2.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and `out_data` stable, `in_ready`=0. Then assert `out_ready` with `in_valid`=1 → same-cycle accept, next state BUSY.
- **Reset mid-operation:** assert `rst` on the second BUSY beat → next cycle IDLE, `out_valid`=0, `out_data`=0. A subsequent fresh accept produces a correct result.
- **Input changes during BUSY:** toggle `in_data`/`in_inv` every cycle while busy → the result matches the value captured at accept.
